// File: rtl/wb_elastic_buffer_pkg.sv
// wb_elastic_buffer_pkg
//
// Shared definitions for the M5-to-writeback elastic buffer:
//   WORD_SIZE        width of pc and result
//   INSTR_TYPE_SZ    width of the instruction type field
//   ROB_ENTRY_WIDTH  width of a ROB id
//   wb_entry_t       one buffered payload {instruction_type, pc, result, rob_id}
//   rob_age()        distance of a ROB id from the oldest in-flight id, modulo
//                    the ROB id space, so that ids compare correctly across wrap
package wb_elastic_buffer_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int INSTR_TYPE_SZ   = 3;
    localparam int ROB_ENTRY_WIDTH = 4;

    typedef struct packed {
        logic [INSTR_TYPE_SZ-1:0]   instruction_type;
        logic [WORD_SIZE-1:0]       pc;
        logic [WORD_SIZE-1:0]       result;
        logic [ROB_ENTRY_WIDTH-1:0] rob_id;
    } wb_entry_t;

    // Unsigned subtraction in ROB_ENTRY_WIDTH bits gives the modular distance.
    function automatic logic [ROB_ENTRY_WIDTH-1:0] rob_age(
        input logic [ROB_ENTRY_WIDTH-1:0] id,
        input logic [ROB_ENTRY_WIDTH-1:0] head_id
    );
        return id - head_id;
    endfunction

endpackage

// File: rtl/wb_elastic_buffer_age_cmp.sv
// wb_buf_age_cmp
//
// Combinational keep mask for a selective squash. An id survives when it is
// no younger than the last surviving id, with age measured relative to the
// oldest in-flight ROB id so wrap-around of the id space is handled.
//
// Ports:
//   rob_head_id    oldest in-flight ROB id (age reference)
//   squash_rob_id  last ROB id that survives the squash
//   ids            N packed ROB ids to test
//   keep           one bit per id, 1 = survives
module wb_buf_age_cmp
    import wb_elastic_buffer_pkg::*;
#(
    parameter int N = 5
)
(
    input  logic [ROB_ENTRY_WIDTH-1:0]   rob_head_id,
    input  logic [ROB_ENTRY_WIDTH-1:0]   squash_rob_id,
    input  logic [N*ROB_ENTRY_WIDTH-1:0] ids,
    output logic [N-1:0]                 keep
);

    logic [ROB_ENTRY_WIDTH-1:0] limit_age;

    assign limit_age = rob_age(squash_rob_id, rob_head_id);

    always_comb begin
        keep = '0;
        for (int i = 0; i < N; i++) begin
            keep[i] = (rob_age(ids[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH], rob_head_id) <= limit_age);
        end
    end

endmodule

// File: rtl/wb_elastic_buffer.sv
// wb_elastic_buffer
//
// In-order DEPTH-entry elastic buffer between the M5 stage and writeback with
// a valid/ready handshake on both sides. Supports a full flush and, when built
// with the WB_BUF_SQUASH_EN macro, a ROB-relative selective squash that
// truncates the youngest entries.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   flush                      discard every entry at the next edge
//   in_valid / in_ready        producer handshake
//   in_instruction_type, in_pc, in_result, in_rob_id   incoming payload
//   out_valid / out_ready      writeback handshake
//   out_instruction_type, out_pc, out_result, out_rob_id  head payload
//   count                      number of occupied entries
//   squash_valid, squash_rob_id, rob_head_id   squash request
//                              (only with WB_BUF_SQUASH_EN)
module wb_elastic_buffer
    import wb_elastic_buffer_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
    input  logic [WORD_SIZE-1:0]       in_pc,
    input  logic [WORD_SIZE-1:0]       in_result,
    input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_TYPE_SZ-1:0]   out_instruction_type,
    output logic [WORD_SIZE-1:0]       out_pc,
    output logic [WORD_SIZE-1:0]       out_result,
    output logic [ROB_ENTRY_WIDTH-1:0] out_rob_id,
    output logic [$clog2(DEPTH):0]     count
`ifdef WB_BUF_SQUASH_EN
    ,
    input  logic                       squash_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] squash_rob_id,
    input  logic [ROB_ENTRY_WIDTH-1:0] rob_head_id
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    wb_entry_t        in_entry;
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W-1:0] head_nxt, tail_nxt, wr_ptr;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             wr_en;
    logic             push, pop;

    assign in_entry = '{instruction_type: in_instruction_type,
                        pc:               in_pc,
                        result:           in_result,
                        rob_id:           in_rob_id};

    // Ready comes from registered occupancy only, so a full buffer never
    // accepts a push even when the head is popped in the same cycle.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    assign out_instruction_type = mem[head].instruction_type;
    assign out_pc               = mem[head].pc;
    assign out_result           = mem[head].result;
    assign out_rob_id           = mem[head].rob_id;

`ifdef WB_BUF_SQUASH_EN
    logic [(DEPTH+1)*ROB_ENTRY_WIDTH-1:0] cmp_ids;
    logic [DEPTH:0]                       cmp_keep;
    logic [CNT_W-1:0]                     survivors;
    logic                                 pop_sq, push_sq;

    // Stored ids plus the incoming id in the top slot, so the incoming entry
    // is judged by exactly the same age test as the stored ones.
    always_comb begin
        cmp_ids = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cmp_ids[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] = mem[i].rob_id;
        end
        cmp_ids[DEPTH*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] = in_rob_id;
    end

    wb_buf_age_cmp #(
        .N (DEPTH + 1)
    ) u_age_cmp (
        .rob_head_id   (rob_head_id),
        .squash_rob_id (squash_rob_id),
        .ids           (cmp_ids),
        .keep          (cmp_keep)
    );

    // Survivors are counted over occupied slots walking from the head, so
    // stale ids in free slots never contribute.
    always_comb begin
        survivors = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && cmp_keep[PTR_W'(head + PTR_W'(i))]) begin
                survivors = survivors + CNT_W'(1);
            end
        end
    end

    assign pop_sq  = pop && cmp_keep[head];
    assign push_sq = push && cmp_keep[DEPTH];
`endif

    // Next-state pointers and occupancy: flush beats squash beats normal flow.
    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count_q;
        wr_en     = 1'b0;
        wr_ptr    = tail;
        if (flush) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end
`ifdef WB_BUF_SQUASH_EN
        else if (squash_valid) begin
            // Survivors form a prefix from the head, so the first free slot
            // after truncation sits at head + survivors.
            wr_en     = push_sq;
            wr_ptr    = head + survivors[PTR_W-1:0];
            head_nxt  = head + PTR_W'(pop_sq);
            count_nxt = survivors + CNT_W'(push_sq) - CNT_W'(pop_sq);
            tail_nxt  = head_nxt + count_nxt[PTR_W-1:0];
        end
`endif
        else begin
            wr_en     = push;
            head_nxt  = head + PTR_W'(pop);
            tail_nxt  = tail + PTR_W'(push);
            count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state: only pointers and count are reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head_nxt;
            tail    <= tail_nxt;
            count_q <= count_nxt;
        end
    end

    // Payload storage is never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_ptr] <= in_entry;
        end
    end

endmodule

// File: tb/tb_wb_elastic_buffer.sv
// tb_wb_elastic_buffer
//
// Directed and randomized stimulus for wb_elastic_buffer, compared every
// cycle against a queue-based reference model of the buffer contents.
// Squash scenarios are exercised when built with WB_BUF_SQUASH_EN.
module tb_wb_elastic_buffer;
    import wb_elastic_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [INSTR_TYPE_SZ-1:0]   in_instruction_type;
    logic [WORD_SIZE-1:0]       in_pc;
    logic [WORD_SIZE-1:0]       in_result;
    logic [ROB_ENTRY_WIDTH-1:0] in_rob_id;
    logic                       out_valid;
    logic                       out_ready;
    logic [INSTR_TYPE_SZ-1:0]   out_instruction_type;
    logic [WORD_SIZE-1:0]       out_pc;
    logic [WORD_SIZE-1:0]       out_result;
    logic [ROB_ENTRY_WIDTH-1:0] out_rob_id;
    logic [CNT_W-1:0]           count;
`ifdef WB_BUF_SQUASH_EN
    logic                       squash_valid;
    logic [ROB_ENTRY_WIDTH-1:0] squash_rob_id;
    logic [ROB_ENTRY_WIDTH-1:0] rob_head_id;
`endif

    int vectors     = 0;
    int miscompares = 0;

    wb_entry_t model_q[$];

    wb_elastic_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_instruction_type  (in_instruction_type),
        .in_pc                (in_pc),
        .in_result            (in_result),
        .in_rob_id            (in_rob_id),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_instruction_type (out_instruction_type),
        .out_pc               (out_pc),
        .out_result           (out_result),
        .out_rob_id           (out_rob_id),
        .count                (count)
`ifdef WB_BUF_SQUASH_EN
        ,
        .squash_valid         (squash_valid),
        .squash_rob_id        (squash_rob_id),
        .rob_head_id          (rob_head_id)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic rdy, input logic [WORD_SIZE-1:0] pc,
                                  input logic [ROB_ENTRY_WIDTH-1:0] id);
        in_valid            = v;
        out_ready           = rdy;
        in_pc               = pc;
        in_rob_id           = id;
        in_result           = pc ^ 32'hA5A5_0000;
        in_instruction_type = pc[2:0];
    endtask

`ifdef WB_BUF_SQUASH_EN
    function automatic int age_of(input logic [ROB_ENTRY_WIDTH-1:0] id);
        return (int'(id) - int'(rob_head_id) + (1 << ROB_ENTRY_WIDTH)) % (1 << ROB_ENTRY_WIDTH);
    endfunction
`endif

    // Compare visible state with the model, then advance the model by the
    // handshake rules for the inputs currently applied, and clock once.
    task automatic tick();
        int        sz;
        bit        do_pop, do_push;
        wb_entry_t in_e;
        sz = model_q.size();
        check_output("count", 32'(count), 32'(sz));
        check_output("in_ready", 32'(in_ready), 32'(sz < DEPTH));
        check_output("out_valid", 32'(out_valid), 32'(sz != 0));
        if (sz != 0) begin
            check_output("out_pc", out_pc, model_q[0].pc);
            check_output("out_result", out_result, model_q[0].result);
            check_output("out_type", 32'(out_instruction_type), 32'(model_q[0].instruction_type));
            check_output("out_rob_id", 32'(out_rob_id), 32'(model_q[0].rob_id));
        end
        in_e = '{instruction_type: in_instruction_type, pc: in_pc, result: in_result, rob_id: in_rob_id};
        if (reset || flush) begin
            model_q.delete();
        end
`ifdef WB_BUF_SQUASH_EN
        else if (squash_valid) begin
            wb_entry_t kept[$];
            int        lim;
            lim = age_of(squash_rob_id);
            do_pop  = out_ready && sz > 0 && age_of(model_q[0].rob_id) <= lim;
            do_push = in_valid && sz < DEPTH && age_of(in_rob_id) <= lim;
            foreach (model_q[i]) if (age_of(model_q[i].rob_id) <= lim) kept.push_back(model_q[i]);
            model_q = kept;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_e);
        end
`endif
        else begin
            do_pop  = out_ready && sz > 0;
            do_push = in_valid && sz < DEPTH;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        apply_stimulus(1'b0, 1'b0, '0, '0);
`ifdef WB_BUF_SQUASH_EN
        squash_valid  = 1'b0;
        squash_rob_id = '0;
        rob_head_id   = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check_output("reset_count", 32'(count), 32'd0);
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);

        // Single entry latency: visible the cycle after the push, then popped.
        apply_stimulus(1'b1, 1'b1, 32'h100, 4'd2);
        tick();
        check_output("latency_pc", out_pc, 32'h100);
        apply_stimulus(1'b0, 1'b1, '0, '0);
        tick();
        check_output("drain_count", 32'(count), 32'd0);

        // Fill to DEPTH with writeback stalled, offer a fifth entry.
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(1'b1, 1'b0, 32'h200 + 32'(i * 4), ROB_ENTRY_WIDTH'(i));
            tick();
        end
        check_output("full_count", 32'(count), 32'(DEPTH));
        check_output("full_in_ready", 32'(in_ready), 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h2F0, 4'd9);
        tick();
        // Pop while full: the offered entry must still be refused this cycle.
        apply_stimulus(1'b1, 1'b1, 32'h2F4, 4'd10);
        tick();
        apply_stimulus(1'b0, 1'b0, '0, '0);
        check_output("reopen_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Drain, then stream ten entries with writeback always ready.
        apply_stimulus(1'b0, 1'b1, '0, '0);
        repeat (DEPTH) tick();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b1, 32'h300 + 32'(i * 4), ROB_ENTRY_WIDTH'(i));
            tick();
            check_output("stream_count", 32'(count), 32'd1);
        end
        apply_stimulus(1'b0, 1'b1, '0, '0);
        tick();

        // Full buffer flushed while both handshakes are active.
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(1'b1, 1'b0, 32'h400 + 32'(i * 4), ROB_ENTRY_WIDTH'(i));
            tick();
        end
        apply_stimulus(1'b1, 1'b1, 32'h4F0, 4'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        check_output("flush_count", 32'(count), 32'd0);
        check_output("flush_out_valid", 32'(out_valid), 32'd0);
        tick();

`ifdef WB_BUF_SQUASH_EN
        // Squash across ROB id wrap: head id 14, entries 15,0,1,2, keep up to 0.
        rob_head_id = 4'd14;
        apply_stimulus(1'b1, 1'b0, 32'h500, 4'd15); tick();
        apply_stimulus(1'b1, 1'b0, 32'h504, 4'd0);  tick();
        apply_stimulus(1'b1, 1'b0, 32'h508, 4'd1);  tick();
        apply_stimulus(1'b1, 1'b0, 32'h50C, 4'd2);  tick();
        apply_stimulus(1'b0, 1'b0, '0, '0);
        squash_valid  = 1'b1;
        squash_rob_id = 4'd0;
        tick();
        check_output("squash_count", 32'(count), 32'd2);
        check_output("squash_head_id", 32'(out_rob_id), 32'd15);
        // Squash with a surviving head pop and a too-young incoming entry.
        apply_stimulus(1'b1, 1'b1, 32'h510, 4'd1);
        tick();
        squash_valid = 1'b0;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        check_output("squash_pop_count", 32'(count), 32'd1);
        check_output("squash_pop_id", 32'(out_rob_id), 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b1, '0, '0);
        tick();
        rob_head_id = '0;
`endif

        // Reset while holding three entries with a push offered.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, 32'h600 + 32'(i * 4), ROB_ENTRY_WIDTH'(i));
            tick();
        end
        apply_stimulus(1'b1, 1'b0, 32'h6F0, 4'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        check_output("midreset_count", 32'(count), 32'd0);
        check_output("midreset_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                           $urandom, ROB_ENTRY_WIDTH'($urandom));
            flush = ($urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 79) == 0);
            tick();
        end
        flush = 1'b0;
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b1, '0, '0);
        repeat (DEPTH + 1) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_elastic_buffer.md
# wb_elastic_buffer

Parametrised elastic buffer between the M5 (memory) stage and writeback. It replaces the single stall-gated M5/WB register with a DEPTH-entry in-order FIFO using a valid/ready handshake. It also supports full flush and, when compiled in, ROB-relative selective squash. Writeback drains it one entry per cycle.

## Interface
- WORD_SIZE, 32, width of pc and result
- INSTR_TYPE_SZ, 3, width of instruction type field
- ROB_ENTRY_WIDTH, 4, width of ROB id
- DEPTH, 4, number of entries; power of two, at least 2
- clk  input  1  clock, rising edge
- reset  input  1  reset reset, synchronous, active-high
- flush  input  1  discard all entries at the next edge
- in_valid  input  1  producer has an entry
- in_ready  output  1  buffer can accept an entry
- in_instruction_type  input  INSTR_TYPE_SZ  payload
- in_pc  input  WORD_SIZE  payload
- in_result  input  WORD_SIZE  payload
- in_rob_id  input  ROB_ENTRY_WIDTH  payload
- out_valid  output  1  head entry present
- out_ready  input  1  writeback consumes the head
- out_instruction_type, out_pc, out_result, out_rob_id  output  as inputs  head payload
- count  output  log2(DEPTH)+1  occupied entries
- squash_valid  input  1  squash request (port present only with WB_BUF_SQUASH_EN)
- squash_rob_id  input  ROB_ENTRY_WIDTH  last surviving ROB id (port present only with WB_BUF_SQUASH_EN)
- rob_head_id  input  ROB_ENTRY_WIDTH  oldest in-flight ROB id, used as the age reference (port present only with WB_BUF_SQUASH_EN)

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready. Entries leave in arrival order.
- in_ready = (count < DEPTH). It depends on registered state only and never combinationally on out_ready. When the buffer is full, a same-cycle pop does not open a slot for a push in that cycle.
- out_valid = (count != 0). The out_* payload is the head entry, driven from registers. The payload is don't-care while out_valid = 0.
- Push and pop in the same cycle leave count unchanged. Both pointers advance and wrap modulo DEPTH.
- Priority order: reset > flush > squash > normal push/pop.
- Flush clears count and both pointers. Any push or pop in the same cycle is ignored.
- Squash (only with WB_BUF_SQUASH_EN):
  - age(x) = (x − rob_head_id) mod 2^ROB_ENTRY_WIDTH.
  - Every entry with age > age(squash_rob_id) is removed; entries are in program order, so this is a tail truncation.
  - The incoming entry is subject to the same test and is dropped if it is too young.
  - A head pop in the same cycle still completes if the head survives.
  - count becomes the number of survivors; the tail pointer becomes head + count.
- Payload registers are never cleared; only the pointers and count are reset.

## Timing
- Reset values: count = 0, out_valid = 0, in_ready = 1, pointers = 0.
- Latency: an entry pushed into an empty buffer at edge N is visible with out_valid = 1 after edge N. There is no combinational in-to-out path.
- Throughput: one entry per cycle in steady state when out_ready is held at 1.
- Reset asserted mid-operation empties the buffer at that edge regardless of handshakes.
- Flush, squash and reset all take effect at the edge where they are sampled. in_ready and count reflect the new state in the following cycle.

## Configuration
- WB_BUF_SQUASH_EN defined: the squash ports and the age-compare logic exist.
- WB_BUF_SQUASH_EN undefined: the squash ports are absent and only flush can discard entries.

## Structure
- Shared package holds WORD_SIZE, INSTR_TYPE_SZ, ROB_ENTRY_WIDTH and a packed wb_entry_t typedef {instruction_type, pc, result, rob_id}. It also holds the rob_age() function.
- One sub-module, wb_buf_age_cmp: combinational per-entry keep mask from rob_head_id, squash_rob_id and the stored ids. It is instantiated only under the macro.

## Test plan
- Empty buffer, push pc=0x100 rob_id=2 with out_ready=1 -> out_valid=1 with out_pc=0x100 the next cycle, popped that cycle, count returns to 0.
- Push 4 entries with out_ready=0 and DEPTH=4 -> count=4, in_ready=0; a fifth in_valid is not accepted; then pulse out_ready for 1 cycle -> in_ready=1 next cycle.
- Continuous push/pop for 10 cycles with out_ready=1 -> count stays at 1 and outputs appear in order across pointer wrap.
- Full buffer, flush=1 with push and pop asserted -> count=0, out_valid=0, nothing output that cycle.
- Squash: rob_head_id=14, entries hold ids 15,0,1,2 and squash_rob_id=0 -> ids 15,0 remain, count=2; check wrap-around of the age compare.
- Reset asserted while count=3 and in_valid=1 -> count=0 and in_ready=1 after the edge.
